fpu_mult_pipe: RTL
==================

// Module: fpu_mult_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754 floating-point multiplier. Successor to the combinational
//  single-precision multiplier in the common FPU library.
//  Adds generic exponent/mantissa widths, round-to-nearest-even, and Inf/NaN/zero special cases.
//  Adds full exception flags and a 3-stage valid/ready pipeline with back-pressure.
//  Sits between the FPU operand dispatcher and the result writeback arbiter.
// PARAMETERS
//  EXP_W   8   exponent field width (8 = single, 11 = double)
//  MAN_W   23  stored mantissa width, hidden bit excluded (23 = single, 52 = double)
//  WIDTH   1+EXP_W+MAN_W  operand/result width (derived; do not override)
// PORTS
//  clk         in   1      clock, all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      operand pair A/B valid
//  in_ready    out  1      stage 1 can accept; transfer when in_valid & in_ready
//  A           in   WIDTH  operand A {sign, exp, man}
//  B           in   WIDTH  operand B
//  out_valid   out  1      result and flags valid
//  out_ready   in   1      consumer accepts; transfer when out_valid & out_ready
//  result      out  WIDTH  product
//  overflow    out  1      rounded exponent exceeds max finite; result = signed Inf
//  underflow   out  1      nonzero true result below min normal; result = signed zero (FTZ)
//  invalid     out  1      Inf*0 or any NaN input; result = canonical qNaN
//  inexact     out  1      rounding discarded nonzero bits, or overflow/underflow occurred
// BEHAVIOUR
//  Reset: s1/s2/s3 valid = 0; result, all flags = 0; out_valid = 0; in_ready = 1 the cycle after rst falls.
//  Reset mid-operation: every in-flight operation is discarded silently, with no partial output.
//  Latency: 3 cycles from accept to out_valid with no stall; throughput 1/cycle.
//  Pipeline: a stage loads when it is empty or its contents move on in the same cycle.
//   in_ready = !s1_v | (s1 advances); it is combinational from out_ready through the stages.
//   Max 3 ops in flight; while out_valid & !out_ready, result and flags hold stable.
//   Ops complete in order; simultaneous accept and output in one cycle is legal.
//  S1 (unpack/multiply): split fields.
//   Inputs with exp==0 are treated as zero (denormal-in flushed).
//   sign = sA^sB; classify {zero, inf, nan, normal}; P = {1,mA}*{1,mB} (2*MAN_W+2 bits).
//   E = eA+eB-BIAS, held as signed EXP_W+2 bits; BIAS = 2^(EXP_W-1)-1.
//  S2 (normalise/round):
//   If P MSB = 1, shift right 1 and E += 1.
//   Keep MAN_W bits; guard = next bit; sticky = OR of the rest.
//   Round-to-nearest-even: inc = guard & (sticky | lsb).
//   If the mantissa carries out, it becomes 0 and E += 1.
//  S3 (pack/flags), priority order:
//   1. NaN input -> qNaN {0, all-ones exp, 1, zeros}, invalid=1.
//   2. Inf*0 -> qNaN, invalid=1.
//   3. Inf input -> {sign, all-ones, 0}.
//   4. Zero input -> {sign, 0}, no flags.
//   5. E >= 2^EXP_W - 1 -> {sign, Inf}, overflow=1, inexact=1.
//   6. E <= 0 -> {sign, 0}, underflow=1, inexact=1.
//   7. Otherwise {sign, E[EXP_W-1:0], man}, inexact = guard|sticky.
//  Flags are per-result and qualified by out_valid; they do not accumulate.
// STRUCTURE
//  Shared package fpu_pkg holds:
//   - class encoding (FP_ZERO/FP_NORM/FP_INF/FP_NAN);
//   - functions for BIAS, qNaN and Inf patterns, parametrised by EXP_W/MAN_W;
//   - flag vector index constants.
//  One sub-module: fpu_round_rne (mantissa, guard, sticky -> rounded mantissa, carry, inexact).
//   It is combinational and instantiated in S2. Other adders may reuse it.
//  Stage registers and handshake live in this module. No FSM beyond the per-stage valid bits.
// TESTING (default EXP_W=8, MAN_W=23)
//  Basic multiply:
//   3FC00000 * 40000000 -> 40400000 (1.5*2=3.0) after exactly 3 cycles; all flags 0.
//  Rounding (RNE):
//   3F800001 * 3F800001 -> 3F800002, inexact=1.
//   3F800000 * BF800000 -> BF800000, inexact=0.
//  Overflow / underflow:
//   7F000000 * 7F000000 -> 7F800000, overflow=1, inexact=1.
//   00800000 * 00800000 -> 00000000, underflow=1, inexact=1.
//  Special operands:
//   7F800000 * 00000000 -> 7FC00000, invalid=1.
//   FF800000 * 40000000 -> FF800000, no flags.
//   7FC00001 * anything -> 7FC00000, invalid=1.
//  Back-pressure:
//   Hold out_ready=0 and offer 5 ops back-to-back. in_ready deasserts after 3 accepted.
//   Release out_ready: all 5 results emerge in order, none lost or duplicated.
//   result is stable while stalled.
//  Reset mid-flight:
//   Assert rst for 1 cycle with 2 ops in flight. No out_valid follows.
//   The next op issued after reset returns correctly after 3 cycles.
//  Random:
//   10k random normal operand pairs with random valid/ready toggling.
//   Compare against a shortreal reference model with FTZ applied.
//  Repeat the basic-multiply, rounding and overflow/underflow cases with EXP_W=11, MAN_W=52.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP class encoding, flag indices and bit-pattern helpers
package fpu_pkg;
  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;
  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OV = 2;
  localparam int FLG_NV = 3;
  localparam int FLG_W  = 4;
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [127:0] fp_inf(input int exp_w, input int man_w);
    return ((128'(1) << exp_w) - 128'(1)) << man_w;
  endfunction
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (128'(1) << (man_w - 1));
  endfunction
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones, input logic man_zero);
    return exp_zero ? FP_ZERO : !exp_ones ? FP_NORM : man_zero ? FP_INF : FP_NAN;
  endfunction
endpackage

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: round-to-nearest-even of a mantissa given guard and sticky bits
module fpu_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0] man_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  output logic [MAN_W-1:0] man_o,
  output logic             carry_o,
  output logic             inexact_o
);
  assign {carry_o, man_o} = {1'b0, man_i} + (MAN_W+1)'(guard_i & (sticky_i | man_i[0]));
  assign inexact_o = guard_i | sticky_i;
endmodule

// File: rtl/fpu_mult_pipe.sv
// fpu_mult_pipe: 3-stage valid/ready IEEE-754 multiplier with RNE, FTZ and exception flags
module fpu_mult_pipe
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             invalid,
  output logic             inexact
);
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [WIDTH-1:0] INF  = WIDTH'(fp_inf(EXP_W, MAN_W));
  localparam logic [WIDTH-1:0] QNAN = WIDTH'(fp_qnan(EXP_W, MAN_W));
  logic v1_q, v2_q, v3_q, en1, en2, en3;
  assign en3 = !v3_q | out_ready;
  assign en2 = !v2_q | en3;
  assign en1 = !v1_q | en2;
  assign in_ready = en1;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  assign {ea, ma} = A[WIDTH-2:0];
  assign {eb, mb} = B[WIDTH-2:0];
  fp_class_e ca_d, cb_d, s1_ca_q, s1_cb_q, s2_ca_q, s2_cb_q;
  logic s1_sign_q, s2_sign_q, s2_nx_q;
  logic [PW-1:0] s1_p_d, s1_p_q, pn;
  logic signed [EW-1:0] s1_e_d, s1_e_q, s2_e_d, s2_e_q;
  logic [MAN_W-1:0] rman, s2_man_q;
  logic rcarry, rnx;
  assign ca_d   = fp_classify(ea == '0, &ea, ma == '0);
  assign cb_d   = fp_classify(eb == '0, &eb, mb == '0);
  assign s1_p_d = PW'({1'b1, ma}) * PW'({1'b1, mb});
  assign s1_e_d = EW'(ea) + EW'(eb) - BIAS;
  assign pn = s1_p_q[PW-1] ? s1_p_q : s1_p_q << 1;
  fpu_round_rne #(.MAN_W(MAN_W)) u_round (
    .man_i    (pn[PW-2 -: MAN_W]),
    .guard_i  (pn[MAN_W]),
    .sticky_i (|pn[MAN_W-1:0]),
    .man_o    (rman),
    .carry_o  (rcarry),
    .inexact_o(rnx)
  );
  assign s2_e_d = s1_e_q + EW'(s1_p_q[PW-1]) + EW'(rcarry);
  logic nan, inf, zero, nv, ovf, unf, special;
  logic [WIDTH-1:0] res_d, res_q, sinf, szero;
  logic [FLG_W-1:0] flg_d, flg_q;
  assign nan     = s2_ca_q == FP_NAN || s2_cb_q == FP_NAN;
  assign inf     = s2_ca_q == FP_INF || s2_cb_q == FP_INF;
  assign zero    = s2_ca_q == FP_ZERO || s2_cb_q == FP_ZERO;
  assign nv      = nan | (inf & zero);
  assign special = nan | inf | zero;
  assign ovf     = s2_e_q >= EMAX;
  assign unf     = s2_e_q[EW-1] | ~|s2_e_q;
  assign sinf    = {s2_sign_q, INF[WIDTH-2:0]};
  assign szero   = {s2_sign_q, {(WIDTH-1){1'b0}}};
  assign res_d   = nv ? QNAN : (inf | (!zero & ovf)) ? sinf : (zero | unf) ? szero :
                   {s2_sign_q, s2_e_q[EXP_W-1:0], s2_man_q};
  always_comb begin
    flg_d = '0;
    flg_d[FLG_NV] = nv;
    flg_d[FLG_OV] = !special & ovf;
    flg_d[FLG_UF] = !special & !ovf & unf;
    flg_d[FLG_NX] = !special & (ovf | unf | s2_nx_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
      if (en3 && v2_q) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end
    end
    if (en1 && in_valid) begin
      s1_sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
      s1_ca_q   <= ca_d;
      s1_cb_q   <= cb_d;
      s1_p_q    <= s1_p_d;
      s1_e_q    <= s1_e_d;
    end
    if (en2 && v1_q) begin
      s2_sign_q <= s1_sign_q;
      s2_ca_q   <= s1_ca_q;
      s2_cb_q   <= s1_cb_q;
      s2_e_q    <= s2_e_d;
      s2_man_q  <= rman;
      s2_nx_q   <= rnx;
    end
  end
  assign out_valid = v3_q;
  assign result    = res_q;
  assign overflow  = flg_q[FLG_OV];
  assign underflow = flg_q[FLG_UF];
  assign invalid   = flg_q[FLG_NV];
  assign inexact   = flg_q[FLG_NX];
endmodule
